// File: rtl/pipe_drain_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_drain_fifo
//  Description : Drain stage for the verification pipeline. Buffers result
//                words in a shallow circular FIFO, hands them out with a
//                valid/ready handshake, and measures push-to-pop residency
//                of the tagged (tracked) word.
//                Optional macro DRAIN_BYPASS_EN: when the FIFO is empty the
//                incoming word is presented combinationally and may be
//                consumed in the same cycle without touching storage.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_drain_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_tag,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_tag,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     tag_done,
    output logic [7:0]               tag_lat
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);
    localparam logic [7:0] c_LAT_MAX = 8'hFF;

    // Tracker state encoding
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_TRACK = 1'b1
    } trk_state_t;

    // Storage and pointers; each entry is {tag, data}
    logic [WIDTH:0]         r_mem [DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;

    // Tracker registers
    trk_state_t             r_state;
    logic [7:0]             r_lat_cnt;
    logic                   r_tag_done;
    logic [7:0]             r_tag_lat;

    // Combinational helpers
    logic                   w_empty;
    logic                   w_in_ready;
    logic [WIDTH:0]         w_head;
    logic                   w_bypass;
    logic                   w_bypass_take;
    logic                   w_accept;
    logic                   w_pop;
    logic                   w_wr_en;
    logic                   w_rd_en;
    logic                   w_tag_push;
    logic                   w_tag_pop;
    logic [7:0]             w_lat_inc;

    assign w_empty    = (r_count == '0);
    // Readiness depends on occupancy only: a full FIFO refuses even while popping
    assign w_in_ready = (r_count != c_FULL_CNT);
    assign w_head     = r_mem[r_rd_ptr];

`ifdef DRAIN_BYPASS_EN
    // Empty FIFO with a word arriving: present it straight through
    assign w_bypass  = w_empty && in_valid;
    assign out_valid = !w_empty || w_bypass;
    assign out_data  = w_bypass ? in_data : w_head[WIDTH-1:0];
    assign out_tag   = w_bypass ? in_tag  : w_head[WIDTH];
`else
    assign w_bypass  = 1'b0;
    assign out_valid = !w_empty;
    assign out_data  = w_head[WIDTH-1:0];
    assign out_tag   = w_head[WIDTH];
`endif

    assign in_ready      = w_in_ready;
    assign count         = r_count;
    assign tag_done      = r_tag_done;
    assign tag_lat       = r_tag_lat;

    // A bypassed word is accepted and consumed in one cycle, never stored
    assign w_bypass_take = w_bypass && out_ready;
    assign w_accept      = in_valid && w_in_ready;
    assign w_pop         = out_valid && out_ready;
    assign w_wr_en       = w_accept && !w_bypass_take;
    assign w_rd_en       = w_pop && !w_bypass_take;

    assign w_tag_push    = w_accept && in_tag;
    assign w_tag_pop     = w_pop && out_tag;
    assign w_lat_inc     = (r_lat_cnt == c_LAT_MAX) ? c_LAT_MAX : (r_lat_cnt + 8'd1);

    // Storage writes; contents are cleared on reset so every state bit is defined
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[r_wr_ptr] <= {in_tag, in_data};
        end
    end

    // Pointers wrap naturally modulo DEPTH (power of two); count tracks occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Residency tracker: arm on tagged push, report on tagged pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_lat_cnt  <= 8'd0;
            r_tag_done <= 1'b0;
            r_tag_lat  <= 8'd0;
        end else begin
            r_tag_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_bypass_take && in_tag) begin
                        // Tagged word entered and left in the same cycle
                        r_tag_done <= 1'b1;
                        r_tag_lat  <= 8'd1;
                    end else if (w_tag_push) begin
                        r_state   <= ST_TRACK;
                        r_lat_cnt <= 8'd0;
                    end
                end
                ST_TRACK: begin
                    // The pop cycle counts toward residency, hence +1 at completion;
                    // a simultaneous tagged push is not tracked
                    if (w_tag_pop) begin
                        r_state    <= ST_IDLE;
                        r_tag_done <= 1'b1;
                        r_tag_lat  <= w_lat_inc;
                    end else begin
                        r_lat_cnt  <= w_lat_inc;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
